// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one strobe-style memory port between two masters that use the
// 4-phase read/write -> done handshake. Port 0 is the CPU, port 1 the DMA/debug master.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   m<p>_addr/_wdata      master p address / write data (stable while requesting)
//   m<p>_read/_write      master p request; read wins when both are high
//   m<p>_rdata/_done      master p read data (held) / completion
//   mem_addr/_wdata       registered memory address / write data
//   mem_re/_we            one-cycle read / write strobes
//   mem_rdata             memory read data, sampled WAIT_STATES cycles after the strobe cycle
//   grant                 port that owns, or last owned, the bus
//   busy                  high while an access or its completion handshake is in progress
//
// Configuration
//   BUS_ARB_RR_EN         defined: round-robin on simultaneous requests (port not served last
//                         wins; port 0 wins first). Undefined: port 0 always wins.

module bus_arbiter #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned WS_W        = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_read,
  input  logic              m0_write,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_done,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_read,
  input  logic              m1_write,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              grant,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e            state_q, state_d;
  logic [WS_W-1:0]   cnt_q, cnt_d;
  logic              grant_q, grant_d;
  logic              is_read_q, is_read_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              re_q, re_d, we_q, we_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              done0_q, done0_d, done1_q, done1_d;

  logic req0, req1, win, win_read;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

`ifdef BUS_ARB_RR_EN
  logic last_q, last_d;
  // On a tie the port not served last wins; a lone request wins outright.
  assign win = (req0 & req1) ? ~last_q : ~req0;
`else
  assign win = ~req0;
`endif

  assign win_read = win ? m1_read : m0_read;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    is_read_d = is_read_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    re_d      = 1'b0;
    we_d      = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    done0_d   = done0_q;
    done1_d   = done1_q;
`ifdef BUS_ARB_RR_EN
    last_d    = last_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req0 | req1) begin
          grant_d   = win;
          addr_d    = win ? m1_addr : m0_addr;
          wdata_d   = win ? m1_wdata : m0_wdata;
          is_read_d = win_read;
          re_d      = win_read;
          we_d      = ~win_read;
          cnt_d     = WAIT_STATES[WS_W-1:0];
`ifdef BUS_ARB_RR_EN
          last_d    = win;
`endif
          state_d   = StAccess;
        end
      end
      StAccess: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          if (is_read_q) begin
            if (grant_q) rdata1_d = mem_rdata;
            else         rdata0_d = mem_rdata;
          end
          if (grant_q) done1_d = 1'b1;
          else         done0_d = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        // Completion ends only once the owner has withdrawn its request.
        if (grant_q ? ~req1 : ~req0) begin
          done0_d = 1'b0;
          done1_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      grant_q   <= 1'b0;
      is_read_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      re_q      <= 1'b0;
      we_q      <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
`ifdef BUS_ARB_RR_EN
      last_q    <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      is_read_q <= is_read_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      re_q      <= re_d;
      we_q      <= we_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
`ifdef BUS_ARB_RR_EN
      last_q    <= last_d;
`endif
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_re    = re_q;
  assign mem_we    = we_q;
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;
  assign m0_done   = done0_q;
  assign m1_done   = done1_q;
  assign grant     = grant_q;
  assign busy      = (state_q == StAccess) || (state_q == StDone);

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized bench for bus_arbiter. Two behavioural masters follow the 4-phase handshake
// (with occasional early request withdrawal and random mid-run resets); a timestamp-based
// transaction model predicts every DUT output each cycle.

module tb_bus_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;
  localparam int unsigned WS = 1;
  localparam int NCYC = 4000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] m0_addr, m1_addr, mem_addr;
  logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, mem_wdata, mem_rdata;
  logic          m0_read, m0_write, m1_read, m1_write, m0_done, m1_done;
  logic          mem_re, mem_we, grant, busy;

  bus_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(WS), .WS_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_read(m0_read), .m0_write(m0_write),
    .m0_rdata(m0_rdata), .m0_done(m0_done),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_read(m1_read), .m1_write(m1_write),
    .m1_rdata(m1_rdata), .m1_done(m1_done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Transaction model: owner of the bus (-1 when free), the edge it was granted at,
  // and the predicted values of every output.
  int            owner;
  int            grant_edge;
  logic          e_read;
  logic          last_srv;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  logic          e_re, e_we, e_grant;
  logic [DW-1:0] e_rdata [2];
  logic          e_done  [2];

  // Master stimulus state: 0 idle, 1 requesting, 2 withdrawn and waiting for release.
  int            ph [2];
  logic          rd [2], wr [2];
  logic [AW-1:0] ad [2];
  logic [DW-1:0] wd [2];

  always_comb begin
    m0_read = rd[0]; m0_write = wr[0]; m0_addr = ad[0]; m0_wdata = wd[0];
    m1_read = rd[1]; m1_write = wr[1]; m1_addr = ad[1]; m1_wdata = wd[1];
  end

  task automatic model_reset();
    owner = -1; grant_edge = 0; e_read = 1'b0; last_srv = 1'b1;
    e_addr = '0; e_wdata = '0; e_re = 1'b0; e_we = 1'b0; e_grant = 1'b0;
    for (int p = 0; p < 2; p++) begin
      e_rdata[p] = '0;
      e_done[p]  = 1'b0;
    end
  endtask

  task automatic model_step();
    bit req [2];
    int w;
    req[0] = rd[0] | wr[0];
    req[1] = rd[1] | wr[1];
    e_re = 1'b0;
    e_we = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else if (owner < 0) begin
      if (req[0] || req[1]) begin
`ifdef BUS_ARB_RR_EN
        if (req[0] && req[1]) w = (last_srv == 1'b1) ? 0 : 1;
        else                  w = req[0] ? 0 : 1;
`else
        w = req[0] ? 0 : 1;
`endif
        owner = w; grant_edge = cyc; last_srv = w[0];
        e_read = rd[w]; e_addr = ad[w]; e_wdata = wd[w];
        e_re = rd[w]; e_we = !rd[w]; e_grant = w[0];
      end
    end else if (!e_done[owner]) begin
      if (cyc == grant_edge + 1 + WS) begin
        if (e_read) e_rdata[owner] = mem_rdata;
        e_done[owner] = 1'b1;
      end
    end else if (!req[owner]) begin
      e_done[owner] = 1'b0;
      owner = -1;
    end
  endtask

  task automatic drive_masters();
    int op;
    for (int p = 0; p < 2; p++) begin
      case (ph[p])
        0: if ($urandom_range(0, 2) == 0) begin
          op = $urandom_range(0, 2);  // 0 read, 1 write, 2 both
          rd[p] = (op != 1); wr[p] = (op != 0);
          ad[p] = AW'($urandom); wd[p] = DW'($urandom);
          ph[p] = 1;
        end
        1: if (owner == p && e_done[p] && $urandom_range(0, 1) == 0) begin
          rd[p] = 1'b0; wr[p] = 1'b0; ph[p] = 2;
        end else if (owner == p && !e_done[p] && $urandom_range(0, 40) == 0) begin
          rd[p] = 1'b0; wr[p] = 1'b0; ph[p] = 2;  // protocol violation: early drop
        end
        default: if (owner != p) ph[p] = 0;
      endcase
    end
  endtask

  task automatic check_all();
    check("mem_re", 32'(mem_re), 32'(e_re));
    check("mem_we", 32'(mem_we), 32'(e_we));
    check("mem_addr", 32'(mem_addr), 32'(e_addr));
    check("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
    check("grant", 32'(grant), 32'(e_grant));
    check("busy", 32'(busy), 32'(owner >= 0));
    check("m0_done", 32'(m0_done), 32'(e_done[0]));
    check("m1_done", 32'(m1_done), 32'(e_done[1]));
    check("m0_rdata", 32'(m0_rdata), 32'(e_rdata[0]));
    check("m1_rdata", 32'(m1_rdata), 32'(e_rdata[1]));
  endtask

  initial begin
    rst_n = 1'b0;
    mem_rdata = 8'h3E;
    for (int p = 0; p < 2; p++) begin
      ph[p] = 0; rd[p] = 1'b0; wr[p] = 1'b0; ad[p] = '0; wd[p] = '0;
    end
    model_reset();
    for (int i = 0; i < NCYC; i++) begin
      @(posedge clk);
      cyc++;
      model_step();
      @(negedge clk);
      check_all();
      if (i == 2) begin
        rst_n = 1'b1;
        // Simultaneous start: m0 reads 0x1234 while m1 writes 0xA5 to 0x8000.
        rd[0] = 1'b1; wr[0] = 1'b0; ad[0] = 16'h1234; wd[0] = 8'h00; ph[0] = 1;
        rd[1] = 1'b0; wr[1] = 1'b1; ad[1] = 16'h8000; wd[1] = 8'hA5; ph[1] = 1;
      end else if (i > 2) begin
        rst_n = ($urandom_range(0, 150) != 0);
        drive_masters();
      end
      mem_rdata = DW'($urandom);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
